// File: rtl/mda_vram_isa_if.sv
// ISA-side bus bundle for the MDA VRAM arbiter: decode hit, strobes, address/data
// and the read-data/ready signals returned to the bus.
interface mda_vram_isa_if;
  logic        mem_select;
  logic        bus_memr_l;
  logic        bus_memw_l;
  logic [11:0] bus_addr;
  logic [7:0]  bus_din;
  logic [7:0]  bus_dout;
  logic        bus_dout_oe;
  logic        iochrdy;

  modport slave (
    input  mem_select, bus_memr_l, bus_memw_l, bus_addr, bus_din,
    output bus_dout, bus_dout_oe, iochrdy
  );

  modport master (
    output mem_select, bus_memr_l, bus_memw_l, bus_addr, bus_din,
    input  bus_dout, bus_dout_oe, iochrdy
  );
endinterface

// File: rtl/mda_vram_isa.sv
// ISA access port into MDA video RAM: slots one ISA byte read/write into the
// display sequencer's free window, stretching the bus cycle with IOCHRDY.
module mda_vram_isa (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              isa_op_enable,
  input  logic              vram_read,
  mda_vram_isa_if.slave     isa,
  output logic [11:0]       ram_addr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din,
  output logic              ram_we_l,
  output logic              isa_ram_sel,
  output logic              collision
);

  typedef enum logic [2:0] {IDLE, WAIT_WIN, OP1, OP2, OP3, HOLD} state_e;

  state_e      state_q, state_d;
  logic        memr_prev_q, memr_prev_d;
  logic        memw_prev_q, memw_prev_d;
  logic        is_write_q, is_write_d;
  logic [11:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        iochrdy_q, iochrdy_d;
  logic        oe_q, oe_d;
  logic [7:0]  dout_q, dout_d;
  logic        we_l_q, we_l_d;
  logic        sel_q, sel_d;
  logic [11:0] ram_addr_q, ram_addr_d;
  logic [7:0]  ram_dout_q, ram_dout_d;
  logic        collision_q, collision_d;

  logic detect_r, detect_w, strobe_low;

  // A request is a single strobe falling while the other stays high; both low is ignored.
  assign detect_r   = isa.mem_select && !isa.bus_memr_l && isa.bus_memw_l && memr_prev_q;
  assign detect_w   = isa.mem_select && !isa.bus_memw_l && isa.bus_memr_l && memw_prev_q;
  assign strobe_low = is_write_q ? !isa.bus_memw_l : !isa.bus_memr_l;

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case infers a latch.
    state_d     = state_q;
    memr_prev_d = isa.bus_memr_l;
    memw_prev_d = isa.bus_memw_l;
    is_write_d  = is_write_q;
    addr_d      = addr_q;
    data_d      = data_q;
    iochrdy_d   = iochrdy_q;
    oe_d        = oe_q;
    dout_d      = dout_q;
    we_l_d      = we_l_q;
    sel_d       = sel_q;
    ram_addr_d  = ram_addr_q;
    ram_dout_d  = ram_dout_q;
    collision_d = collision_q | (vram_read & sel_q);

    unique case (state_q)
      IDLE: begin
        if (detect_r || detect_w) begin
          addr_d     = isa.bus_addr;
          data_d     = isa.bus_din;
          is_write_d = detect_w;
          iochrdy_d  = 1'b0;
          state_d    = WAIT_WIN;
        end
      end
      WAIT_WIN: begin
        if (!strobe_low) begin
          iochrdy_d = 1'b1;
          state_d   = IDLE;
        end else if (isa_op_enable && !vram_read) begin
          sel_d      = 1'b1;
          ram_addr_d = addr_q;
          ram_dout_d = data_q;
          state_d    = OP1;
        end
      end
      OP1: begin
        we_l_d  = !is_write_q;
        state_d = OP2;
      end
      OP2: begin
        we_l_d  = 1'b1;
        state_d = OP3;
      end
      OP3: begin
        iochrdy_d = 1'b1;
        sel_d     = 1'b0;
        if (!is_write_q) begin
          dout_d = ram_din;
          oe_d   = 1'b1;
        end
        state_d = HOLD;
      end
      HOLD: begin
        if (!strobe_low) begin
          oe_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobe history resets to "low" so a strobe held through reset needs a fresh fall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      memr_prev_q <= 1'b0;
      memw_prev_q <= 1'b0;
      is_write_q  <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      iochrdy_q   <= 1'b1;
      oe_q        <= 1'b0;
      dout_q      <= '0;
      we_l_q      <= 1'b1;
      sel_q       <= 1'b0;
      ram_addr_q  <= '0;
      ram_dout_q  <= '0;
      collision_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values computed above.
      state_q     <= state_d;
      memr_prev_q <= memr_prev_d;
      memw_prev_q <= memw_prev_d;
      is_write_q  <= is_write_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      iochrdy_q   <= iochrdy_d;
      oe_q        <= oe_d;
      dout_q      <= dout_d;
      we_l_q      <= we_l_d;
      sel_q       <= sel_d;
      ram_addr_q  <= ram_addr_d;
      ram_dout_q  <= ram_dout_d;
      collision_q <= collision_d;
    end
  end

  assign isa.iochrdy     = iochrdy_q;
  assign isa.bus_dout    = dout_q;
  assign isa.bus_dout_oe = oe_q;
  assign ram_addr        = ram_addr_q;
  assign ram_dout        = ram_dout_q;
  assign ram_we_l        = we_l_q;
  assign isa_ram_sel     = sel_q;
  assign collision       = collision_q;

endmodule

// File: tb/tb_mda_vram_isa.sv
// Bench for mda_vram_isa: free-running 20-count sequencer (window 6..15, display
// fetch 0..3), a VRAM array, and a byte-level reference memory.
module tb_mda_vram_isa;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        isa_op_enable, vram_read;
  logic [11:0] ram_addr;
  logic [7:0]  ram_dout, ram_din;
  logic        ram_we_l, isa_ram_sel, collision;

  always #5 clk = ~clk;

  mda_vram_isa_if bus();

  mda_vram_isa dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .isa_op_enable (isa_op_enable),
    .vram_read     (vram_read),
    .isa           (bus),
    .ram_addr      (ram_addr),
    .ram_dout      (ram_dout),
    .ram_din       (ram_din),
    .ram_we_l      (ram_we_l),
    .isa_ram_sel   (isa_ram_sel),
    .collision     (collision)
  );

  // Sequencer model, with a manual override for directed collision stimulus.
  int seq_cnt = 0;
  bit man_mode = 1'b0, man_en = 1'b0, man_rd = 1'b0;
  always @(posedge clk) seq_cnt <= (seq_cnt + 1) % 20;
  assign isa_op_enable = man_mode ? man_en : (seq_cnt >= 6 && seq_cnt <= 15);
  assign vram_read     = man_mode ? man_rd : (seq_cnt < 4);

  // VRAM device and reference contents.
  logic [7:0] vram    [4096];
  logic [7:0] ref_mem [4096];
  assign ram_din = vram[ram_addr];
  always @(posedge clk) if (!ram_we_l) vram[ram_addr] <= ram_dout;

  int         we_pulses = 0;
  logic [11:0] we_addr;
  logic [7:0]  we_data;
  always @(negedge clk) if (!ram_we_l) begin
    we_pulses++;
    we_addr = ram_addr;
    we_data = ram_dout;
  end

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit in_window(int n);
    return man_mode ? man_en : (n >= 6 && n <= 15);
  endfunction

  task automatic wait_cnt(input int v);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (seq_cnt == v) break;
    end
    check("seq_wait", seq_cnt, v);
  endtask

  // One full ISA cycle, started at the current negedge; checks latency, data and VRAM strobes.
  task automatic isa_access(input bit wr, input logic [11:0] a, input logic [7:0] d,
                            input int hold_extra);
    int k, low, p0;
    k = 1;
    while (!in_window((seq_cnt + k) % 20)) k++;
    p0 = we_pulses;
    bus.bus_addr   = a;
    bus.bus_din    = d;
    bus.mem_select = 1'b1;
    if (wr) bus.bus_memw_l = 1'b0; else bus.bus_memr_l = 1'b0;
    low = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.iochrdy) break;
      low++;
    end
    check("latency", low, k + 3);
    if (wr) begin
      check("oe_wr", bus.bus_dout_oe, 1'b0);
      ref_mem[a] = d;
    end else begin
      check("rdata", bus.bus_dout, ref_mem[a]);
      check("oe_rd", bus.bus_dout_oe, 1'b1);
    end
    if (hold_extra > 0) begin
      repeat (hold_extra) @(negedge clk);
      if (!wr) begin
        check("hold_rdata", bus.bus_dout, ref_mem[a]);
        check("hold_oe", bus.bus_dout_oe, 1'b1);
      end
    end
    bus.bus_memr_l = 1'b1;
    bus.bus_memw_l = 1'b1;
    bus.mem_select = 1'b0;
    @(negedge clk);
    check("oe_release", bus.bus_dout_oe, 1'b0);
    check("we_count", we_pulses - p0, wr ? 1 : 0);
    if (wr) begin
      check("we_addr", we_addr, a);
      check("we_data", we_data, d);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit");
    $fatal(1);
  end

  initial begin
    int p0, bad, lowcnt;
    for (int i = 0; i < 4096; i++) begin
      vram[i]    = 8'($urandom);
      ref_mem[i] = vram[i];
    end
    bus.mem_select = 1'b0;
    bus.bus_memr_l = 1'b1;
    bus.bus_memw_l = 1'b1;
    bus.bus_addr   = '0;
    bus.bus_din    = '0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_iochrdy", bus.iochrdy, 1'b1);
    check("rst_oe", bus.bus_dout_oe, 1'b0);
    check("rst_dout", bus.bus_dout, 8'h00);
    check("rst_we_l", ram_we_l, 1'b1);
    check("rst_sel", isa_ram_sel, 1'b0);
    check("rst_ram_addr", ram_addr, 12'h000);
    check("rst_ram_dout", ram_dout, 8'h00);
    check("rst_collision", collision, 1'b0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Write 0x5A to 0x123 with the window open one cycle after detect.
    wait_cnt(7);
    isa_access(1'b1, 12'h123, 8'h5A, 0);

    // Read 0x7FF detected at count 16: waits for the window to reopen at 6.
    vram[12'h7FF]    = 8'hC3;
    ref_mem[12'h7FF] = 8'hC3;
    wait_cnt(16);
    isa_access(1'b0, 12'h7FF, 8'h00, 3);

    // Both strobes fall together: ignored.
    @(negedge clk);
    p0 = we_pulses;
    bus.mem_select = 1'b1;
    bus.bus_addr   = 12'h055;
    bus.bus_memr_l = 1'b0;
    bus.bus_memw_l = 1'b0;
    lowcnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (!bus.iochrdy || isa_ram_sel) lowcnt++;
    end
    check("both_low_busy", lowcnt, 0);
    check("both_low_we", we_pulses - p0, 0);
    bus.bus_memr_l = 1'b1;
    bus.bus_memw_l = 1'b1;
    bus.mem_select = 1'b0;

    // Write aborted while waiting for the window.
    wait_cnt(16);
    p0 = we_pulses;
    bus.mem_select = 1'b1;
    bus.bus_addr   = 12'h0AB;
    bus.bus_din    = 8'h11;
    bus.bus_memw_l = 1'b0;
    @(negedge clk);
    check("abort_wait", bus.iochrdy, 1'b0);
    @(negedge clk);
    bus.bus_memw_l = 1'b1;
    bus.mem_select = 1'b0;
    @(negedge clk);
    check("abort_ready", bus.iochrdy, 1'b1);
    repeat (20) @(negedge clk);
    check("abort_we", we_pulses - p0, 0);
    check("abort_mem", vram[12'h0AB], ref_mem[12'h0AB]);

    // Reset pulsed during OP1 of a write; strobe held low through release.
    wait_cnt(7);
    p0 = we_pulses;
    bus.mem_select = 1'b1;
    bus.bus_addr   = 12'h200;
    bus.bus_din    = 8'hEE;
    bus.bus_memw_l = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (isa_ram_sel) break;
    end
    check("op1_reached", isa_ram_sel, 1'b1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_iochrdy", bus.iochrdy, 1'b1);
    check("mid_rst_sel", isa_ram_sel, 1'b0);
    check("mid_rst_we_l", ram_we_l, 1'b1);
    check("mid_rst_ram_addr", ram_addr, 12'h000);
    check("mid_rst_ram_dout", ram_dout, 8'h00);
    check("mid_rst_dout", bus.bus_dout, 8'h00);
    check("mid_rst_oe", bus.bus_dout_oe, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    lowcnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (!bus.iochrdy) lowcnt++;
    end
    check("no_restart", lowcnt, 0);
    check("rst_no_we", we_pulses - p0, 0);
    bus.bus_memw_l = 1'b1;
    bus.mem_select = 1'b0;
    @(negedge clk);
    check("rst_mem", vram[12'h200], ref_mem[12'h200]);

    // Random traffic against the free-running sequencer.
    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      isa_access(1'($urandom), 12'($urandom), 8'($urandom), $urandom_range(0, 2));
    end
    check("collision_clean", collision, 1'b0);
    bad = 0;
    for (int i = 0; i < 4096; i++) if (vram[i] !== ref_mem[i]) bad++;
    check("vram_match", bad, 0);

    // Forced display fetch during an ISA access sets the sticky collision flag.
    @(negedge clk);
    man_mode = 1'b1;
    man_en   = 1'b1;
    man_rd   = 1'b0;
    fork
      isa_access(1'b1, 12'h3C3, 8'h77, 0);
      begin
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (isa_ram_sel) begin
            man_rd = 1'b1;
            break;
          end
        end
        @(negedge clk);
        man_rd = 1'b0;
      end
    join
    check("collision_set", collision, 1'b1);
    repeat (5) @(negedge clk);
    check("collision_sticky", collision, 1'b1);
    reset_n = 1'b0;
    #1;
    check("collision_rst", collision, 1'b0);
    @(negedge clk);
    reset_n  = 1'b1;
    man_mode = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
